// File: rtl/dmem_ctrl.sv
// dmem_ctrl - registered, handshaked data memory for the RV32I load/store path.
//
// Accepts one load/store request at a time in IDLE, optionally waits
// WAIT_STATES cycles, then presents a response until the consumer takes it.
// Stores commit on the acceptance edge. Loads read the word on the last edge
// before the response and right-justify and extend the selected lanes.
// Misaligned, out-of-range and illegal-size requests return rsp_err=1 with
// zero data and never touch memory.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid / req_ready      request handshake (req_ready = state is IDLE)
//   req_we, req_addr, req_size, req_unsigned, req_wdata   request fields
//   rsp_valid / rsp_ready      response handshake
//   rsp_rdata, rsp_err         load result (0 for stores/errors), error flag
module dmem_ctrl #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              we_q, we_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_word_q;

    // ---------------- request decode ----------------
    logic              accept;
    logic [OFF_W-1:0]  req_off;
    logic [IDX_W-1:0]  req_idx;
    logic [ADDR_W-1:0] req_hi;
    logic [3:0]        align_mask;
    logic              req_err;
    logic [NB-1:0]     lane_mask;
    logic [DATA_W-1:0] wdata_sh;

    assign accept     = (state_q == IDLE) && req_valid;
    assign req_off    = req_addr[OFF_W-1:0];
    assign req_idx    = req_addr[OFF_W +: IDX_W];
    // Any address bit above the word index means the index is >= DEPTH.
    assign req_hi     = req_addr >> (OFF_W + IDX_W);
    assign align_mask = (4'd1 << req_size) - 4'd1;
    assign req_err    = (|(req_addr[3:0] & align_mask))
                      || (|req_hi)
                      || ((req_size == 2'd3) && (DATA_W < 64));
    assign wdata_sh   = req_wdata << {req_off, 3'b000};

    // Lane gi is written when it lies in [off, off + bytes_of(size)).
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            assign lane_mask[gi] = (gi >= int'(req_off))
                                && (gi < int'(req_off) + (1 << req_size));
        end
    endgenerate

    // ---------------- memory (no reset, byte-lane writes, registered read) ----------------
    logic             mem_we;
    logic             mem_re;
    logic [IDX_W-1:0] rd_idx;

    assign mem_we = accept && req_we && !req_err;

    // With no wait states the word is read on the acceptance edge straight
    // from the request; otherwise on the last WAIT edge from the latched index.
    generate
        if (WAIT_STATES == 0) begin : g_rd_now
            assign mem_re = accept && !req_we;
            assign rd_idx = req_idx;
        end else begin : g_rd_late
            assign mem_re = (state_q == WAIT) && (cnt_q == '0) && !we_q;
            assign rd_idx = idx_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (lane_mask[i]) begin
                    mem[req_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
                end
            end
        end
        if (mem_re) begin
            rd_word_q <= mem[rd_idx];
        end
    end

    // ---------------- control FSM ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        off_d   = off_q;
        idx_d   = idx_q;
        size_d  = size_q;
        uns_d   = uns_q;
        we_d    = we_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    off_d  = req_off;
                    idx_d  = req_idx;
                    size_d = req_size;
                    uns_d  = req_unsigned;
                    we_d   = req_we;
                    err_d  = req_err;
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(WAIT_STATES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) state_d = RESP;
                else             cnt_d   = cnt_q - 1'b1;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            off_q   <= '0;
            idx_q   <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            off_q   <= off_d;
            idx_q   <= idx_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

    // ---------------- response formatting ----------------
    // Built only from registered state, so nothing on req_* reaches rsp_*.
    logic [DATA_W-1:0] rd_sh;
    logic [DATA_W-1:0] keep;
    logic              sign;
    logic [DATA_W-1:0] load_ext;

    assign rd_sh = rd_word_q >> {off_q, 3'b000};

    always_comb begin
        keep = '1;
        sign = 1'b0;
        case (size_q)
            2'd0: begin keep = DATA_W'(8'hFF);         sign = rd_sh[7];  end
            2'd1: begin keep = DATA_W'(16'hFFFF);      sign = rd_sh[15]; end
            2'd2: begin keep = DATA_W'(32'hFFFF_FFFF); sign = rd_sh[31]; end
            default: begin keep = '1;                  sign = 1'b0;      end
        endcase
    end

    assign load_ext  = (rd_sh & keep) | ((sign && !uns_q) ? ~keep : '0);

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && !err_q && !we_q) ? load_ext : '0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: instance 0 is a 32-bit build with no wait states,
// instance 1 a 64-bit build with three wait states. Requests push their
// expected response into a per-instance queue; a monitor pops and compares on
// each response handshake.
module tb_dmem_ctrl;

    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid    [2];
    logic        req_ready    [2];
    logic        req_we       [2];
    logic [31:0] req_addr     [2];
    logic [1:0]  req_size     [2];
    logic        req_unsigned [2];
    logic [63:0] req_wdata    [2];
    logic        rsp_valid    [2];
    logic        rsp_ready    [2];
    logic        rsp_err      [2];
    logic [63:0] rsp_rdata    [2];
    logic [31:0] rdata_a;
    logic [63:0] rdata_b;

    assign rsp_rdata[0] = {32'h0, rdata_a};
    assign rsp_rdata[1] = rdata_b;

    dmem_ctrl #(.DATA_W(32), .DEPTH(DEPTH), .WAIT_STATES(0), .ADDR_W(32)) u_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
        .req_wdata(req_wdata[0][31:0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rdata_a), .rsp_err(rsp_err[0])
    );

    dmem_ctrl #(.DATA_W(64), .DEPTH(DEPTH), .WAIT_STATES(3), .ADDR_W(32)) u_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
        .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rdata_b), .rsp_err(rsp_err[1])
    );

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        string       name;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compare on every response handshake.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst_n && rsp_valid[d] && rsp_ready[d]) begin
                if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rsp dut%0d: got rdata=%h err=%b, expected none",
                             d, rsp_rdata[d], rsp_err[d]);
                end else begin
                    if (d == 0) mon_e = q0.pop_front();
                    else        mon_e = q1.pop_front();
                    $display("[%0t] dut%0d %s rdata=%h err=%b", $time, d, mon_e.name,
                             rsp_rdata[d], rsp_err[d]);
                    check({mon_e.name, "_rdata"}, rsp_rdata[d], mon_e.rdata);
                    check({mon_e.name, "_err"}, {63'h0, rsp_err[d]}, {63'h0, mon_e.err});
                end
            end
        end
    end

    task automatic drive(input int d, input bit we, input logic [31:0] addr,
                         input logic [1:0] size, input bit uns, input logic [63:0] wdata);
        req_valid[d]    = 1'b1;
        req_we[d]       = we;
        req_addr[d]     = addr;
        req_size[d]     = size;
        req_unsigned[d] = uns;
        req_wdata[d]    = wdata;
    endtask

    // Issue one request (entered 1 time unit after a rising edge, DUT idle),
    // check latency, optional backpressure for 'hold' cycles, and return to IDLE.
    task automatic req(input int d, input string name, input bit we, input logic [31:0] addr,
                       input logic [1:0] size, input bit uns, input logic [63:0] wdata,
                       input logic [63:0] exp_rdata, input bit exp_err, input int hold);
        exp_t e;
        int   ws;
        int   k;
        ws = (d == 0) ? 0 : 3;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.name  = name;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        rsp_ready[d] = (hold == 0);
        check({name, "_ready_idle"}, {63'h0, req_ready[d]}, 64'd1);
        drive(d, we, addr, size, uns, wdata);
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        k = 0;
        while (!rsp_valid[d] && k < 40) begin
            check({name, "_ready_busy"}, {63'h0, req_ready[d]}, 64'd0);
            @(posedge clk); #1;
            k++;
        end
        check({name, "_latency"}, 64'(k), 64'(ws));
        for (int h = 0; h < hold; h++) begin
            check({name, "_hold_valid"}, {63'h0, rsp_valid[d]}, 64'd1);
            check({name, "_hold_ready"}, {63'h0, req_ready[d]}, 64'd0);
            check({name, "_hold_rdata"}, rsp_rdata[d], exp_rdata);
            @(posedge clk); #1;
        end
        rsp_ready[d] = 1'b1;
        @(posedge clk); #1;
        check({name, "_done_valid"}, {63'h0, rsp_valid[d]}, 64'd0);
        check({name, "_done_ready"}, {63'h0, req_ready[d]}, 64'd1);
    endtask

    // Accept a request on instance 1, then reset one cycle later (in WAIT).
    task automatic reset_in_wait(input string name, input bit we, input logic [31:0] addr,
                                 input logic [63:0] wdata);
        drive(1, we, addr, 2'd2, 1'b0, wdata);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        $display("[%0t] dut1 %s reset in WAIT", $time, name);
        check({name, "_rst_valid"}, {63'h0, rsp_valid[1]}, 64'd0);
        check({name, "_rst_ready"}, {63'h0, req_ready[1]}, 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_we[d] = 1'b0;
            req_addr[d] = '0;
            req_size[d] = '0;
            req_unsigned[d] = 1'b0;
            req_wdata[d] = '0;
            rsp_ready[d] = 1'b1;
        end
        #2;
        for (int d = 0; d < 2; d++) begin
            check("reset_req_ready", {63'h0, req_ready[d]}, 64'd1);
            check("reset_rsp_valid", {63'h0, rsp_valid[d]}, 64'd0);
            check("reset_rsp_rdata", rsp_rdata[d], 64'd0);
            check("reset_rsp_err",   {63'h0, rsp_err[d]}, 64'd0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 32-bit, no wait states
        req(0, "sw_10",  1, 32'h10, 2'd2, 0, 64'hDEADBEEF, 64'h0, 0, 0);
        req(0, "lw_10",  0, 32'h10, 2'd2, 0, 64'h0, 64'h0000_0000_DEAD_BEEF, 0, 0);
        req(0, "sh_12",  1, 32'h12, 2'd1, 0, 64'hABCD, 64'h0, 0, 0);
        req(0, "lw_10m", 0, 32'h10, 2'd2, 0, 64'h0, 64'h0000_0000_ABCD_BEEF, 0, 0);
        req(0, "sw_20",  1, 32'h20, 2'd2, 0, 64'h0, 64'h0, 0, 0);
        req(0, "sb_23",  1, 32'h23, 2'd0, 0, 64'h80, 64'h0, 0, 0);
        req(0, "lb_23",  0, 32'h23, 2'd0, 0, 64'h0, 64'h0000_0000_FFFF_FF80, 0, 0);
        req(0, "lbu_23", 0, 32'h23, 2'd0, 1, 64'h0, 64'h0000_0000_0000_0080, 0, 0);
        req(0, "lh_22",  0, 32'h22, 2'd1, 0, 64'h0, 64'h0000_0000_FFFF_8000, 0, 0);
        req(0, "lw_21",  0, 32'h21, 2'd2, 0, 64'h0, 64'h0, 1, 0);
        req(0, "sh_23",  1, 32'h23, 2'd1, 0, 64'h1234, 64'h0, 1, 0);
        req(0, "lw_oor", 0, 4*DEPTH, 2'd2, 0, 64'h0, 64'h0, 1, 0);
        req(0, "ld_32",  0, 32'h8, 2'd3, 0, 64'h0, 64'h0, 1, 0);
        req(0, "lw_20",  0, 32'h20, 2'd2, 0, 64'h0, 64'h0000_0000_8000_0000, 0, 0);
        req(0, "sw_top", 1, 4*DEPTH-4, 2'd2, 0, 64'h5A5A_1234, 64'h0, 0, 0);
        req(0, "lw_top", 0, 4*DEPTH-4, 2'd2, 0, 64'h0, 64'h0000_0000_5A5A_1234, 0, 0);

        // 64-bit, three wait states
        req(1, "sd_08",  1, 32'h8, 2'd3, 0, 64'h0123_4567_89AB_CDEF, 64'h0, 0, 0);
        req(1, "lw_0c",  0, 32'hC, 2'd2, 0, 64'h0, 64'h0000_0000_0123_4567, 0, 0);
        req(1, "lw_08",  0, 32'h8, 2'd2, 0, 64'h0, 64'hFFFF_FFFF_89AB_CDEF, 0, 0);
        req(1, "lwu_08", 0, 32'h8, 2'd2, 1, 64'h0, 64'h0000_0000_89AB_CDEF, 0, 0);
        req(1, "lw_bp",  0, 32'hC, 2'd2, 0, 64'h0, 64'h0000_0000_0123_4567, 0, 5);
        req(1, "ld_0c",  0, 32'hC, 2'd3, 0, 64'h0, 64'h0, 1, 0);
        req(1, "ld_oor", 0, 8*DEPTH, 2'd3, 0, 64'h0, 64'h0, 1, 0);

        // Reset while in WAIT: store stays committed, load is dropped.
        reset_in_wait("sw_rst", 1, 32'h10, 64'hCAFE_F00D);
        reset_in_wait("lw_rst", 0, 32'h8, 64'h0);
        req(1, "lw_10",  0, 32'h10, 2'd2, 0, 64'h0, 64'hFFFF_FFFF_CAFE_F00D, 0, 0);
        req(1, "ld_08",  0, 32'h8, 2'd3, 0, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 0);

        repeat (2) @(posedge clk);
        check("scoreboard_drained", 64'(q0.size() + q1.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised data-memory controller for the RV32I SoPC load/store path. It replaces a combinational-read, always-ready byte-lane RAM with a registered, handshaked memory. Features: configurable width, depth and wait states; load/store size and sign-extension handling; alignment and range checking with an error response. It sits between the MEM stage and on-chip data storage.

## Interface
- DATA_W, 32: data width in bits; legal values are 32 and 64. The block has DATA_W/8 byte lanes.
- DEPTH, 1024: number of DATA_W-wide words; must be a power of two.
- WAIT_STATES, 0: extra cycles inserted before each response; legal range 0..15.
- ADDR_W, 32: byte-address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  a request is presented.
- req_ready  out  1  the block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = dword (dword legal only when DATA_W=64).
- req_unsigned  in  1  for loads, zero-extend instead of sign-extend.
- req_wdata  in  DATA_W  store data, right-justified (the LSBs hold the value).
- rsp_valid  out  1  a response is presented.
- rsp_ready  in  1  the consumer takes the response.
- rsp_rdata  out  DATA_W  load result, extended to full width; 0 for stores and on error.
- rsp_err  out  1  the request was misaligned, out of range, or used an illegal size.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - When req_valid is high, the request is accepted on that edge, address/size/unsigned/we are latched, and the error check is evaluated.
- Error check:
  - Misaligned: req_addr mod (1<<req_size) != 0.
  - Out of range: the word index req_addr[ADDR_W-1:log2(DATA_W/8)] >= DEPTH.
  - Illegal size: req_size=3 with DATA_W=32.
  - Any one of these sets err. An errored store writes nothing.
- Stores:
  - The lane offset is off = req_addr[log2(DATA_W/8)-1:0].
  - Byte mask = ((1<<(1<<req_size))-1) << off.
  - Shifted data = req_wdata << (8*off).
  - Only masked lanes are written. The write commits on the acceptance edge.
- Loads:
  - The word is read on the last edge of WAIT (or the acceptance edge if WAIT_STATES=0).
  - The selected lanes are shifted down by off and then sign- or zero-extended from bit 8*(1<<size)-1.
- Transitions:
  - IDLE -> WAIT on acceptance if WAIT_STATES>0; a down-counter is loaded with WAIT_STATES-1.
  - IDLE -> RESP on acceptance if WAIT_STATES=0.
  - WAIT -> RESP when the counter reaches 0.
  - RESP -> IDLE when rsp_ready=1.
- RESP:
  - rsp_valid=1.
  - rsp_rdata and rsp_err are held stable until the handshake completes.
- Memory contents are not reset; power-up contents are X. The bench must write before it reads.

## Timing
- Reset values (asynchronous assertion of rst_n=0):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - Memory is unaffected.
- Latency:
  - A request accepted at edge N gives rsp_valid=1 in the cycle after edge N+WAIT_STATES.
  - With WAIT_STATES=0 the response is valid one cycle after acceptance.
- Throughput: one request per (WAIT_STATES+2) cycles with rsp_ready tied high. req_ready is 0 outside IDLE.
- rsp_ready held low: the block stays in RESP indefinitely and accepts no new request.
- Store-then-load: a load accepted after a store's response returns the stored data. There is no hazard because the store commits at acceptance.
- Reset mid-operation: any pending response is dropped.
  - A store accepted before reset remains committed.
  - A load in WAIT is abandoned.
- rsp_rdata is registered. No combinational path exists from req_* to rsp_*.
- req_ready depends only on state, not on req_valid.

## Test plan
- Word store/load, DATA_W=32, WAIT_STATES=0:
  - Stimulus: SW 0xDEADBEEF to 0x10, then LW 0x10.
  - Required response: rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid exactly one cycle after each acceptance.
- Byte/half merge and extension:
  - Stimulus: SW 0x00000000 to 0x20, SB 0x80 to 0x23, then LB 0x23, LBU 0x23, LH 0x22.
  - Required response: 0xFFFFFF80, 0x00000080, 0xFFFF8000 respectively.
- Misalignment and range:
  - Stimulus: LW 0x21, SH 0x23, LW 4*DEPTH.
  - Required response: each gives rsp_err=1 and rsp_rdata=0.
  - Follow-up LW 0x20 returns the unchanged word from the previous scenario (0x80000000).
- Wait states and backpressure, WAIT_STATES=3:
  - Stimulus: accept an LW at edge N; hold rsp_ready=0 for 5 cycles.
  - Required response: rsp_valid rises after edge N+3 and holds stable data; req_ready=0 throughout; return to IDLE on the rsp_ready edge.
- 64-bit mode, DATA_W=64:
  - Stimulus: SD 0x0123456789ABCDEF to 0x8, then LW 0xC.
  - Required response: 0x0000000001234567. LW on a DATA_W=64 build sign-extends to 64 bits.
  - On a DATA_W=32 build, size=3 returns rsp_err=1.
- Reset mid-WAIT:
  - Stimulus: pull rst_n low 1 cycle after a load is accepted.
  - Required response: rsp_valid=0 and req_ready=1 immediately.
  - The next request completes normally.
